// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
// MEM-stage initiator for the byte-lane data memory adapter. Loads and stores
// from EX/MEM are checked (funct3 and, optionally, alignment), then issued on
// the adapter's byte-addressed request port. Loads wait for a variable-latency
// read_valid (bounded by a timeout) while the pipeline is stalled, and return
// sign/zero-extended data to writeback as a one-cycle response pulse.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid           request present (held stable while stall=1)
//   req_is_store        1 = store, 0 = load
//   req_funct3          RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr            byte address
//   req_wdata           store data, unshifted (byte0 goes to req_addr)
//   stall               freeze upstream stages
//   resp_valid          one-cycle response pulse
//   resp_fault          qualifies resp_valid: bad funct3, misaligned, timeout
//   resp_rdata          extended load data, 0 on fault
//   mem_address         adapter address
//   mem_write_data      adapter write data
//   mem_write_enable    adapter write enable
//   mem_write_mask      adapter byte mask (bit i = byte i from address)
//   mem_read_enable     adapter read enable
//   mem_read_data       adapter read data (byte0 = byte at mem_address)
//   mem_read_valid      adapter read data valid this cycle
// ---------------------------------------------------------------------------
module lsu_mem_port #(
   parameter int ALLOW_MISALIGNED = 1,
   parameter int TIMEOUT_CYCLES   = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic        resp_fault,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   output logic [3:0]  mem_write_mask,
   output logic        mem_read_enable,
   input  logic [31:0] mem_read_data,
   input  logic        mem_read_valid
);

   // Keep the counter at least one bit wide when the timeout is disabled.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RESP    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [2:0]        f3_q, f3_d;
   logic              resp_fault_q, resp_fault_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;

   logic              accept;
   logic              legal;
   logic              ld_go;
   logic              st_go;

   // funct3 legality plus optional natural-alignment check. funct3[1:0]
   // encodes the size for both loads and stores (0=B, 1=H, 2=W).
   function automatic logic req_legal(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
      logic ok;
      if (is_store) ok = (f3 <= 3'd2);
      else          ok = !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
      if (ALLOW_MISALIGNED == 0) begin
         if ((f3[1:0] == 2'd1) && a[0])          ok = 1'b0;
         if ((f3[1:0] == 2'd2) && (a != 2'b00))  ok = 1'b0;
      end
      return ok;
   endfunction

   // Adapter already rotates lanes, so the addressed byte is always byte0.
   function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                               input logic [31:0] d);
      logic [31:0] r;
      case (f3)
         3'd0:    r = {{24{d[7]}}, d[7:0]};
         3'd1:    r = {{16{d[15]}}, d[15:0]};
         3'd4:    r = {24'd0, d[7:0]};
         3'd5:    r = {16'd0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   assign accept = req_valid && (state_q != S_RD_WAIT);
   assign legal  = req_legal(req_is_store, req_funct3, req_addr[1:0]);
   assign ld_go  = accept && legal && !req_is_store;
   assign st_go  = accept && legal && req_is_store;

   // State register; control and response outputs are reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_fault_q <= resp_fault_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Latched load context; only meaningful while in RD_WAIT.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      f3_q   <= f3_d;
   end

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      f3_d         = f3_q;
      resp_fault_d = 1'b0;
      resp_rdata_d = 32'd0;
      case (state_q)
         S_IDLE, S_RESP: begin
            state_d = S_IDLE;
            if (accept) begin
               if (!legal) begin
                  state_d      = S_RESP;
                  resp_fault_d = 1'b1;
               end else if (!req_is_store) begin
                  state_d = S_RD_WAIT;
                  cnt_d   = '0;
                  addr_d  = req_addr;
                  f3_d    = req_funct3;
               end
            end
         end
         S_RD_WAIT: begin
            if (mem_read_valid) begin
               state_d      = S_RESP;
               resp_rdata_d = load_extend(f3_q, mem_read_data);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if ((TIMEOUT_CYCLES != 0) && (cnt_d == TO_VAL)) begin
                  state_d      = S_RESP;
                  resp_fault_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: memory request port and stall.
   always_comb begin
      mem_address      = 32'd0;
      mem_write_data   = 32'd0;
      mem_write_enable = 1'b0;
      mem_write_mask   = 4'b0000;
      mem_read_enable  = 1'b0;
      if (st_go) begin
         mem_write_enable = 1'b1;
         mem_address      = req_addr;
         mem_write_data   = req_wdata;
         case (req_funct3[1:0])
            2'd0:    mem_write_mask = 4'b0001;
            2'd1:    mem_write_mask = 4'b0011;
            default: mem_write_mask = 4'b1111;
         endcase
      end else if (ld_go) begin
         mem_read_enable = 1'b1;
         mem_address     = req_addr;
      end else if (state_q == S_RD_WAIT) begin
         mem_read_enable = 1'b1;
         mem_address     = addr_q;
      end
      stall = (state_q == S_RD_WAIT) || ld_go;
   end

   assign resp_valid = (state_q == S_RESP);
   assign resp_fault = resp_fault_q;
   assign resp_rdata = resp_rdata_q;

endmodule
